// File: rtl/kf_pkg.sv
// Shared definitions for the Kalman-filter predict datapath: default word format,
// the fixed-point unity constant and the covariance-predict FSM state codes.
package kf_pkg;

  localparam int unsigned KF_N    = 20;
  localparam int unsigned KF_FRAC = 10;
  localparam int          KF_ONE  = 1 << KF_FRAC;

  // Covariance-predict FSM state codes
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StReq  = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StMul0 = 3'd3;
  localparam logic [2:0] StMul1 = 3'd4;
  localparam logic [2:0] StMul2 = 3'd5;
  localparam logic [2:0] StSum  = 3'd6;
  localparam logic [2:0] StDone = 3'd7;

endpackage

// File: rtl/kf_mul_trunc.sv
// Single shared fixed-point multiplier for the covariance predict. The left operand
// is always dt; the right operand is selected by the current FSM state. The result
// keeps bits [FRAC+N-1:FRAC] of the full 2N-bit signed product.
module kf_mul_trunc
  import kf_pkg::*;
#(
  parameter int unsigned N    = KF_N,
  parameter int unsigned FRAC = KF_FRAC
) (
  input  logic [2:0]          state,
  input  logic signed [N-1:0] dt,
  input  logic signed [N-1:0] p11,
  input  logic signed [N-1:0] s,
  input  logic signed [N-1:0] m0,
  output logic signed [N-1:0] prod
);

  logic signed [N-1:0]   b_op;
  logic signed [2*N-1:0] prod_full;

  // Right-operand select: MUL0 dt*P11, MUL1 dt*(P01+P10), MUL2 dt*m0
  always_comb begin
    b_op = '0;
    unique case (state)
      StMul0:  b_op = p11;
      StMul1:  b_op = s;
      StMul2:  b_op = m0;
      default: b_op = '0;
    endcase
  end

  assign prod_full = $signed({{N{dt[N-1]}}, dt}) * $signed({{N{b_op[N-1]}}, b_op});
  assign prod      = N'(prod_full >>> FRAC);

endmodule

// File: rtl/kf_cov_predict_serial.sv
// Kalman covariance predict P' = F*P*F^T + Q for a constant-velocity model, with the
// process-noise (Q) generator handshake on the front. One multiplier used serially.
// Optional: define KF_Q_TIMEOUT_EN to bound the wait for q_done and raise q_timeout.
module kf_cov_predict_serial
  import kf_pkg::*;
#(
  parameter int unsigned N         = KF_N,
  parameter int unsigned FRAC      = KF_FRAC,
  parameter int unsigned Q_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] x00_now,
  input  logic signed [N-1:0] x01_now,
  input  logic signed [N-1:0] P00,
  input  logic signed [N-1:0] P01,
  input  logic signed [N-1:0] P10,
  input  logic signed [N-1:0] P11,
  input  logic signed [N-1:0] dt,
  output logic                busy,
  output logic                q_start,
  output logic signed [N-1:0] q_x00_now,
  output logic signed [N-1:0] q_x01_now,
  output logic signed [N-1:0] q_x00_prev,
  output logic signed [N-1:0] q_x01_prev,
  input  logic                q_done,
  input  logic signed [N-1:0] Q11,
  input  logic signed [N-1:0] Q12,
  input  logic signed [N-1:0] Q21,
  input  logic signed [N-1:0] Q22,
  output logic signed [N-1:0] Pp00,
  output logic signed [N-1:0] Pp01,
  output logic signed [N-1:0] Pp10,
  output logic signed [N-1:0] Pp11,
  output logic                done,
  output logic                q_timeout
);

  logic [2:0]          state_q;
  logic signed [N-1:0] dt_q, p00_q, p01_q, p10_q, p11_q;
  logic signed [N-1:0] prev0_q, prev1_q;
  logic                prev_valid_q;
  logic signed [N-1:0] q11_q, q12_q, q21_q, q22_q;
  logic signed [N-1:0] m0_q, m1_q, m2_q;
  logic signed [N-1:0] s_sum;
  logic signed [N-1:0] mul_p;

`ifdef KF_Q_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(Q_TIMEOUT + 1);
  logic [CntW-1:0] wait_cnt_q;
  logic            q_timeout_q;
  assign q_timeout = q_timeout_q;
`else
  assign q_timeout = 1'b0;
`endif

  assign s_sum   = p01_q + p10_q;
  assign busy    = (state_q != StIdle);
  assign q_start = (state_q == StReq);
  assign done    = (state_q == StDone);

  kf_mul_trunc #(
    .N    (N),
    .FRAC (FRAC)
  ) u_mul (
    .state (state_q),
    .dt    (dt_q),
    .p11   (p11_q),
    .s     (s_sum),
    .m0    (m0_q),
    .prod  (mul_p)
  );

  // FSM, request capture, Q capture and serial multiply/accumulate
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      dt_q         <= '0;
      p00_q        <= '0;
      p01_q        <= '0;
      p10_q        <= '0;
      p11_q        <= '0;
      prev0_q      <= '0;
      prev1_q      <= '0;
      prev_valid_q <= 1'b0;
      q11_q        <= '0;
      q12_q        <= '0;
      q21_q        <= '0;
      q22_q        <= '0;
      m0_q         <= '0;
      m1_q         <= '0;
      m2_q         <= '0;
      q_x00_now    <= '0;
      q_x01_now    <= '0;
      q_x00_prev   <= '0;
      q_x01_prev   <= '0;
      Pp00         <= '0;
      Pp01         <= '0;
      Pp10         <= '0;
      Pp11         <= '0;
`ifdef KF_Q_TIMEOUT_EN
      wait_cnt_q   <= '0;
      q_timeout_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dt_q         <= dt;
            p00_q        <= P00;
            p01_q        <= P01;
            p10_q        <= P10;
            p11_q        <= P11;
            q_x00_now    <= x00_now;
            q_x01_now    <= x01_now;
            // First frame after reset reports zero motion
            q_x00_prev   <= prev_valid_q ? prev0_q : x00_now;
            q_x01_prev   <= prev_valid_q ? prev1_q : x01_now;
            prev0_q      <= x00_now;
            prev1_q      <= x01_now;
            prev_valid_q <= 1'b1;
            state_q      <= StReq;
          end
        end
        StReq: begin
`ifdef KF_Q_TIMEOUT_EN
          wait_cnt_q <= CntW'(1);
`endif
          state_q <= StWait;
        end
        StWait: begin
          if (q_done) begin
            q11_q   <= Q11;
            q12_q   <= Q12;
            q21_q   <= Q21;
            q22_q   <= Q22;
            state_q <= StMul0;
          end
`ifdef KF_Q_TIMEOUT_EN
          // Give up and reuse the last captured Q
          else if (wait_cnt_q == CntW'(Q_TIMEOUT)) begin
            q_timeout_q <= 1'b1;
            state_q     <= StMul0;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
`endif
        end
        StMul0: begin
          m0_q    <= mul_p;
          state_q <= StMul1;
        end
        StMul1: begin
          m1_q    <= mul_p;
          state_q <= StMul2;
        end
        StMul2: begin
          m2_q    <= mul_p;
          state_q <= StSum;
        end
        StSum: begin
          Pp00    <= p00_q + m1_q + m2_q + q11_q;
          Pp01    <= p01_q + m0_q + q12_q;
          Pp10    <= p10_q + m0_q + q21_q;
          Pp11    <= p11_q + q22_q;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
